oric_ram_arbiter: RTL and testbench
===================================

Name: oric_ram_arbiter

Overview:
- Owns the single-port 64 KB system RAM.
- Shares the RAM between three requesters:
  - the Oric core, which has fixed timing and cannot be stalled;
  - a byte-stream loader fed from ioctl, for direct RAM injection of programs;
  - an internal clear engine that fills RAM after reset or on request.
- Sits between the core's ram_* bus and the RAM array.
- Adds no latency to core accesses.

Parameters:
- ADDR_W, 16, RAM address width; sweep length is 2**ADDR_W.
- DATA_W, 8, data width.
- FILL, 8'hFF, byte written by the clear engine.
- FIFO_DEPTH, 4, loader write buffer entries; power of two, minimum 2.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset; also starts a clear sweep.
- clr_start  in  1  one-cycle pulse: (re)start the clear sweep.
- clr_busy  out  1  clear sweep in progress.
- core_addr  in  ADDR_W  core address.
- core_din  in  DATA_W  core write data.
- core_cs  in  1  core access this cycle.
- core_we  in  1  core write; qualified by core_cs.
- core_q  out  DATA_W  read data to core; equals mem_q.
- ld_valid  in  1  loader byte valid.
- ld_ready  out  1  loader byte accepted when ld_valid and ld_ready are both high.
- ld_addr  in  ADDR_W  loader target address.
- ld_data  in  DATA_W  loader byte.
- ld_empty  out  1  loader FIFO holds no pending writes.
- mem_addr  out  ADDR_W  RAM address.
- mem_din  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_q  in  DATA_W  RAM registered read data; 1-cycle latency.

Behaviour:
- States: ST_CLEAR, ST_RUN.
- Reset, while reset is high:
  - state=ST_CLEAR, sweep counter=0, FIFO emptied.
  - clr_busy=1, ld_ready=0, ld_empty=1.
  - mem_we=0, mem_addr=0, mem_din=FILL.
- ST_CLEAR:
  - Each cycle: mem_we=1, mem_addr=counter, mem_din=FILL, counter+1.
  - The first cycle after reset falls writes address 0.
  - After the write to 2**ADDR_W-1: state=ST_RUN; clr_busy=0 from the next cycle.
  - Core accesses are ignored: writes are dropped, core_q is don't-care.
  - ld_ready=0.
- ST_RUN priority, evaluated combinationally each cycle:
  1. core_cs=1: mem_addr=core_addr, mem_din=core_din, mem_we=core_we.
  2. Else FIFO non-empty: mem_addr/mem_din=FIFO head, mem_we=1, pop.
  3. Else: mem_addr=core_addr, mem_din=core_din, mem_we=0.
- Core path:
  - Purely combinational mux; the read result is on core_q one cycle after core_cs, same as a direct RAM connection.
  - The core is never stalled.
  - The loader may starve indefinitely if core_cs is held high; this is accepted.
- FIFO:
  - ld_ready = (state==ST_RUN) and not full.
  - ld_ready is computed from current occupancy, so a pop does not free a slot in the same cycle.
  - Push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Earliest commit of a byte pushed at cycle N is cycle N+1.
  - Entries commit strictly in push order.
  - ld_empty = (count==0).
- Hazards: a core write and a pending loader write to the same address are not tracked; the later commit wins.
- clr_start in any state, or reset at any time, including mid-sweep or mid-drain:
  - FIFO is flushed and pending loader bytes are lost.
  - counter=0, state=ST_CLEAR.
  - The sweep restarts at address 0 on the next cycle.
  - reset has precedence over clr_start.
- Width rules:
  - The sweep counter is ADDR_W+1 bits; the terminal test is counter[ADDR_W-1:0] all ones.
  - FIFO count is $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package oric_mem_pkg holds:
  - ADDR_W, DATA_W and FILL defaults;
  - typedef addr_t and data_t;
  - enum arb_state_t {ST_CLEAR, ST_RUN};
  - typedef ld_entry_t struct {addr_t addr; data_t data;}.
- Sub-module ram_wr_fifo: synchronous FIFO of ld_entry_t with push, pop, flush, full, empty and head outputs.
- The arbiter top holds the sweep counter, state register and priority mux.

Test Plan:
- Reset held 3 cycles then released -> exactly 65536 consecutive cycles of mem_we=1 with mem_addr 0x0000..0xFFFF and mem_din=0xFF; clr_busy falls the cycle after 0xFFFF; ld_ready=1 from then on.
- ST_RUN, core_cs=0, loader pushes {0x0500:0x11, 0x0501:0x22, 0x0502:0x33} on consecutive cycles -> mem_we=1 at 0x0500/0x0501/0x0502 on the three following cycles in order; ld_empty=1 after the last.
- core_cs held 10 cycles with reads at 0x2000 while loader offers 6 bytes -> ld_ready drops after 4 accepts; mem_addr follows core_addr with mem_we=0; after core_cs falls, the 4 buffered bytes commit on 4 consecutive cycles, then the remaining 2.
- Loader writes 0xA5 to 0x1234; core reads 0x1234 after ld_empty=1 -> core_q=0xA5 one cycle after the read cycle.
- 2 loader entries pending under core_cs=1, then a clr_start pulse -> next cycle ld_empty=1, clr_busy=1, mem_addr=0x0000 with mem_din=0xFF; the pending bytes are never written.
- reset asserted when the sweep is at 0x8000 -> after release the sweep restarts at 0x0000 and runs the full 65536 cycles; a core write during ST_CLEAR (0x0100:0x42) never reaches mem_we.

Source files
------------

// File: rtl/oric_mem_pkg.sv
// Shared types and defaults for the Oric system RAM path.
package oric_mem_pkg;

    localparam int unsigned ORIC_ADDR_W = 16;
    localparam int unsigned ORIC_DATA_W = 8;
    localparam logic [7:0]  ORIC_FILL   = 8'hFF;

    typedef logic [ORIC_ADDR_W-1:0] addr_t;
    typedef logic [ORIC_DATA_W-1:0] data_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } arb_state_t;

    typedef struct packed {
        addr_t addr;
        data_t data;
    } ld_entry_t;

endpackage

// File: rtl/ram_wr_fifo.sv
// Small synchronous FIFO buffering loader writes until the RAM port is free.
module ram_wr_fifo
    import oric_mem_pkg::*;
#(
    parameter type         entry_t = ld_entry_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic   clk_sys,
    input  logic   flush,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t             store [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = store[rd_ptr];

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; flush drops everything.
    always_ff @(posedge clk_sys) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/oric_ram_arbiter.sv
// Arbitrates the single-port system RAM between the core, the ioctl loader
// and the post-reset clear sweep. Core accesses pass straight through.
module oric_ram_arbiter
    import oric_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W     = ORIC_ADDR_W,
    parameter int unsigned       DATA_W     = ORIC_DATA_W,
    parameter logic [DATA_W-1:0] FILL       = DATA_W'(ORIC_FILL),
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              clr_start,
    output logic              clr_busy,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_din,
    input  logic              core_cs,
    input  logic              core_we,
    output logic [DATA_W-1:0] core_q,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_empty,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    arb_state_t        state;
    logic [ADDR_W:0]   sweep_cnt;
    logic              sweep_last;
    logic              restart;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    entry_t            fifo_head;
    entry_t            ld_entry;

    assign restart    = reset || clr_start;
    assign sweep_last = &sweep_cnt[ADDR_W-1:0];

    assign ld_entry   = '{addr: ld_addr, data: ld_data};
    assign ld_ready   = !reset && (state == ST_RUN) && !fifo_full;
    assign fifo_push  = ld_valid && ld_ready;
    assign fifo_pop   = (state == ST_RUN) && !core_cs && !fifo_empty && !restart;

    assign clr_busy   = reset || (state == ST_CLEAR);
    assign ld_empty   = reset || fifo_empty;
    assign core_q     = mem_q;

    // Sweep counter and state; the counter MSB marks a finished sweep and
    // blocks any further increment should ST_CLEAR ever be reached with it set.
    always_ff @(posedge clk_sys) begin
        if (restart) begin
            state     <= ST_CLEAR;
            sweep_cnt <= '0;
        end else if (state == ST_CLEAR && !sweep_cnt[ADDR_W]) begin
            sweep_cnt <= sweep_cnt + (ADDR_W+1)'(1);
            if (sweep_last) begin
                state <= ST_RUN;
            end
        end
    end

    ram_wr_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys   (clk_sys),
        .flush     (restart),
        .push      (fifo_push),
        .push_data (ld_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // RAM port mux: reset, clear sweep, core, then buffered loader writes.
    // A clr_start cycle never drains the FIFO, so flushed bytes cannot leak.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = core_addr;
        mem_din  = core_din;
        if (reset) begin
            mem_addr = '0;
            mem_din  = FILL;
        end else if (state == ST_CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = sweep_cnt[ADDR_W-1:0];
            mem_din  = FILL;
        end else if (core_cs) begin
            mem_we   = core_we;
        end else if (fifo_pop) begin
            mem_we   = 1'b1;
            mem_addr = fifo_head.addr;
            mem_din  = fifo_head.data;
        end
    end

endmodule

// File: tb/tb_oric_ram_arbiter.sv
// Self-checking bench for oric_ram_arbiter with a behavioural registered RAM.
module tb_oric_ram_arbiter;

    localparam int unsigned AW    = 14;
    localparam int unsigned DW    = 8;
    localparam int unsigned SWEEP = 1 << AW;
    localparam int unsigned HALF  = SWEEP / 2;
    localparam logic [7:0]  FILLV = 8'hFF;

    logic          clk_sys = 1'b0;
    logic          reset, clr_start, clr_busy;
    logic [AW-1:0] core_addr, ld_addr, mem_addr;
    logic [DW-1:0] core_din, core_q, ld_data, mem_din, mem_q;
    logic          core_cs, core_we, ld_valid, ld_ready, ld_empty, mem_we;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t sb_q[$];

    typedef struct {
        logic cs; logic we; logic [AW-1:0] ca; logic [DW-1:0] cd;
        logic lv; logic [AW-1:0] la; logic [DW-1:0] ld;
        logic e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_din;
        logic e_rdy; logic e_empty; logic chk_q; logic [DW-1:0] e_q;
    } vec_t;
    vec_t vecs[9];

    logic [DW-1:0] ram [SWEEP];

    always #5 clk_sys = ~clk_sys;

    // Registered single-port RAM, read-before-write.
    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_q <= ram[mem_addr];
    end

    oric_ram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FILL       (FILLV),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .core_addr (core_addr),
        .core_din  (core_din),
        .core_cs   (core_cs),
        .core_we   (core_we),
        .core_q    (core_q),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_empty  (ld_empty),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_q     (mem_q)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic vec_t mk(input logic cs, input logic we, input logic [AW-1:0] ca,
                                input logic [DW-1:0] cd, input logic lv, input logic [AW-1:0] la,
                                input logic [DW-1:0] ld, input logic e_we, input logic [AW-1:0] e_addr,
                                input logic [DW-1:0] e_din, input logic e_rdy, input logic e_empty,
                                input logic chk_q, input logic [DW-1:0] e_q);
        vec_t v;
        v.cs = cs; v.we = we; v.ca = ca; v.cd = cd; v.lv = lv; v.la = la; v.ld = ld;
        v.e_we = e_we; v.e_addr = e_addr; v.e_din = e_din; v.e_rdy = e_rdy;
        v.e_empty = e_empty; v.chk_q = chk_q; v.e_q = e_q;
        return v;
    endfunction

    // Loader/core writes seen on the RAM port must match the expected queue in order.
    always @(negedge clk_sys) begin
        if (mon_en && mem_we) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h:%0h expected none", mem_addr, mem_din);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("sb_addr", mem_addr, e.addr);
                chk("sb_data", mem_din, e.data);
            end
        end
    end

    // Expects the sweep to begin at the next negedge with address 0.
    task automatic run_sweep(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < SWEEP; i++) begin
            @(negedge clk_sys);
            if (!(mem_we === 1'b1 && mem_addr === i[AW-1:0] && mem_din === FILLV &&
                  clr_busy === 1'b1 && ld_ready === 1'b0))
                bad++;
            if (i == 20) begin
                core_cs = 1'b0;
                core_we = 1'b0;
            end
        end
        chk(name, bad, 0);
        @(negedge clk_sys);
        chk("busy_after_sweep", clr_busy, 0);
        chk("ready_after_sweep", ld_ready, 1);
        chk("we_after_sweep", mem_we, 0);
    endtask

    initial begin
        int idx;
        reset = 1'b1; clr_start = 1'b0;
        core_cs = 1'b0; core_we = 1'b0; core_addr = '0; core_din = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;

        // Reset held for three edges.
        repeat (2) cyc();
        @(negedge clk_sys);
        chk("rst_busy", clr_busy, 1);
        chk("rst_ready", ld_ready, 0);
        chk("rst_empty", ld_empty, 1);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_din, FILLV);
        cyc();
        reset = 1'b0;
        run_sweep("sweep_first");

        // Loader burst and core pass-through, one vector per cycle.
        vecs[0] = mk(0, 0, 14'h0000, 8'h00, 1, 14'h0500, 8'h11, 0, 14'h0000, 8'h00, 1, 1, 0, 8'h00);
        vecs[1] = mk(0, 0, 14'h0000, 8'h00, 1, 14'h0501, 8'h22, 1, 14'h0500, 8'h11, 1, 0, 0, 8'h00);
        vecs[2] = mk(0, 0, 14'h0000, 8'h00, 1, 14'h0502, 8'h33, 1, 14'h0501, 8'h22, 1, 0, 0, 8'h00);
        vecs[3] = mk(0, 0, 14'h0000, 8'h00, 0, 14'h0000, 8'h00, 1, 14'h0502, 8'h33, 1, 0, 0, 8'h00);
        vecs[4] = mk(0, 0, 14'h0000, 8'h00, 0, 14'h0000, 8'h00, 0, 14'h0000, 8'h00, 1, 1, 0, 8'h00);
        vecs[5] = mk(1, 0, 14'h0500, 8'h00, 0, 14'h0000, 8'h00, 0, 14'h0500, 8'h00, 1, 1, 0, 8'h00);
        vecs[6] = mk(1, 1, 14'h0600, 8'h77, 0, 14'h0000, 8'h00, 1, 14'h0600, 8'h77, 1, 1, 1, 8'h11);
        vecs[7] = mk(1, 0, 14'h0502, 8'h00, 0, 14'h0000, 8'h00, 0, 14'h0502, 8'h00, 1, 1, 0, 8'h00);
        vecs[8] = mk(0, 0, 14'h0000, 8'h00, 0, 14'h0000, 8'h00, 0, 14'h0000, 8'h00, 1, 1, 1, 8'h33);
        for (int v = 0; v < 9; v++) begin
            cyc();
            core_cs = vecs[v].cs; core_we = vecs[v].we;
            core_addr = vecs[v].ca; core_din = vecs[v].cd;
            ld_valid = vecs[v].lv; ld_addr = vecs[v].la; ld_data = vecs[v].ld;
            @(negedge clk_sys);
            chk($sformatf("vec%0d_we", v), mem_we, vecs[v].e_we);
            chk($sformatf("vec%0d_addr", v), mem_addr, vecs[v].e_addr);
            chk($sformatf("vec%0d_din", v), mem_din, vecs[v].e_din);
            chk($sformatf("vec%0d_ready", v), ld_ready, vecs[v].e_rdy);
            chk($sformatf("vec%0d_empty", v), ld_empty, vecs[v].e_empty);
            if (vecs[v].chk_q) chk($sformatf("vec%0d_q", v), core_q, vecs[v].e_q);
        end

        // Core holds the port for 10 cycles while the loader offers 6 bytes.
        mon_en = 1'b1;
        idx = 0;
        for (int c = 0; c < 40 && !(c > 10 && idx == 6 && sb_q.size() == 0); c++) begin
            cyc();
            core_cs = (c < 10); core_we = 1'b0; core_addr = 14'h2000;
            ld_valid = (idx < 6);
            ld_addr = 14'h0700 + AW'(idx);
            ld_data = 8'h60 + DW'(idx);
            @(negedge clk_sys);
            if (core_cs) begin
                chk("cs_hold_we", mem_we, 0);
                chk("cs_hold_addr", mem_addr, 14'h2000);
            end
            if (ld_valid && ld_ready) begin
                sb_q.push_back('{ld_addr, ld_data});
                idx++;
            end
            if (c == 9) begin
                chk("accepts_under_cs", idx, 4);
                chk("ready_when_full", ld_ready, 0);
            end
        end
        ld_valid = 1'b0;
        chk("all_accepted", idx, 6);
        chk("drain_done", sb_q.size(), 0);
        @(negedge clk_sys);
        chk("empty_after_drain", ld_empty, 1);

        // Loader byte then core read-back.
        cyc();
        ld_valid = 1'b1; ld_addr = 14'h1234; ld_data = 8'hA5;
        @(negedge clk_sys);
        chk("a5_ready", ld_ready, 1);
        if (ld_ready) sb_q.push_back('{14'h1234, 8'hA5});
        cyc();
        ld_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_sys);
            if (ld_empty) break;
        end
        chk("a5_empty", ld_empty, 1);
        cyc();
        core_cs = 1'b1; core_addr = 14'h1234;
        cyc();
        core_cs = 1'b0;
        @(negedge clk_sys);
        chk("a5_readback", core_q, 8'hA5);

        // Two bytes pending under core_cs, then clr_start flushes them.
        cyc();
        core_cs = 1'b1; core_we = 1'b0; core_addr = 14'h2000;
        ld_valid = 1'b1; ld_addr = 14'h3000; ld_data = 8'h5A;
        @(negedge clk_sys);
        chk("flush_push0", ld_ready, 1);
        cyc();
        ld_addr = 14'h3001; ld_data = 8'h5B;
        @(negedge clk_sys);
        chk("flush_push1", ld_ready, 1);
        cyc();
        ld_valid = 1'b0; clr_start = 1'b1;
        @(negedge clk_sys);
        chk("two_pending", ld_empty, 0);
        cyc();
        clr_start = 1'b0; core_cs = 1'b0; mon_en = 1'b0;
        @(negedge clk_sys);
        chk("clr_empty", ld_empty, 1);
        chk("clr_busy", clr_busy, 1);
        chk("clr_addr0", mem_addr, 0);
        chk("clr_din", mem_din, FILLV);
        chk("clr_we", mem_we, 1);

        // Reset mid-sweep with a core write present; the sweep must restart.
        repeat (HALF) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("mid_addr", mem_addr, HALF);
        reset = 1'b1;
        core_cs = 1'b1; core_we = 1'b1; core_addr = 14'h0100; core_din = 8'h42;
        #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_busy", clr_busy, 1);
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        run_sweep("sweep_after_reset");

        // Dropped core write and flushed loader bytes left the fill in place.
        cyc();
        core_cs = 1'b1; core_we = 1'b0; core_addr = 14'h0100;
        cyc();
        core_addr = 14'h3000;
        @(negedge clk_sys);
        chk("no_core_write", core_q, FILLV);
        cyc();
        core_cs = 1'b0;
        @(negedge clk_sys);
        chk("no_flushed_write", core_q, FILLV);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
